// File: rtl/sccb_write_funcmod_pkg.sv
// sccb_write_funcmod_pkg: shared state encoding, SCCB constants and bus-drive decode for the SCCB write engine
package sccb_write_funcmod_pkg;
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, GAP, WAIT, DONE} stateT;
  typedef struct packed {
    logic c;
    logic d;
    logic oe;
  } busT;
  localparam logic [7:0] SCCB_ID_WRITE = 8'h42;
  localparam logic [7:0] COM7_ADDR = 8'h12;
  localparam int BIT_COUNT = 27;
  localparam int BIT_W = $clog2(BIT_COUNT);
  // Slots 8, 17 and 26 (0-based) are the ack slots that follow each byte.
  function automatic logic isAckBit(input logic [BIT_W-1:0] b);
    return (b == BIT_W'(8)) || (b == BIT_W'(17)) || (b == BIT_W'(26));
  endfunction
  // Pin levels for a given state and quarter; every state not listed idles the bus high.
  function automatic busT busDrive(input stateT s, input logic [1:0] q, input logic ack, input logic b);
    busT r;
    r.c = (s == START) ? (q < 2'd2) : (s == BIT) ? (q == 2'd1 || q == 2'd2) : (s == STOP) ? (q != 2'd0) : 1'b1;
    r.d = (s == START) ? (q == 2'd0) : (s == BIT) ? (ack | b) : (s == STOP) ? q[1] : 1'b1;
    r.oe = !(s == BIT && ack);
    return r;
  endfunction
endpackage

// File: rtl/sccb_write_funcmod_tick.sv
// sccb_tick_gen: quarter-period strobe every CLK_DIV clocks with synchronous restart
//   CLOCK    in  system clock
//   RESET    in  asynchronous active-low reset
//   iRestart in  hold the divider at phase zero
//   oTick    out one-cycle strobe on the last clock of each quarter
module sccb_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic iRestart,
  output logic oTick
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] count;
  assign oTick = (count == LAST);
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) count <= '0;
    else count <= (iRestart || oTick) ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/sccb_write_funcmod.sv
// sccb_write_funcmod: SCCB 3-phase write engine (ID, sub-address, data) behind a call/done handshake
//   CLOCK     in  system clock
//   RESET     in  asynchronous active-low reset
//   iCall     in  write request level, held until oDone
//   iData     in  {register address, register value}, latched on accept
//   oDone     out one-cycle completion pulse
//   oBusy     out high from accept through the oDone cycle
//   oNack     out sticky: some ack slot of the last write sampled high
//   SIO_C     out SCCB clock
//   SIO_D_OUT out SCCB data value
//   SIO_D_OE  out 1 = drive SIO_D_OUT, 0 = release
//   SIO_D_IN  in  SCCB data pin readback
module sccb_write_funcmod
  import sccb_write_funcmod_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter logic [7:0] DEV_ID = SCCB_ID_WRITE,
  parameter int RST_WAIT = 100_000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iCall,
  input  logic [15:0] iData,
  output logic        oDone,
  output logic        oBusy,
  output logic        oNack,
  output logic        SIO_C,
  output logic        SIO_D_OUT,
  output logic        SIO_D_OE,
  input  logic        SIO_D_IN
);
  localparam int WW = $clog2(RST_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RST_WAIT - 1);
  stateT state, stateN;
  logic [1:0] quarter, quarterN;
  logic [BIT_W-1:0] bitCnt, bitN;
  logic [23:0] shiftReg, shiftN;
  logic [WW-1:0] waitCnt;
  logic softReset, tick, ackBit, lastBit;
  busT busN;
  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) tickGen (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .iRestart(state == IDLE),
    .oTick(tick)
  );
  assign ackBit = isAckBit(bitCnt);
  assign lastBit = (bitCnt == BIT_W'(BIT_COUNT - 1));
  always_comb begin
    stateN = state;
    quarterN = quarter;
    bitN = bitCnt;
    shiftN = shiftReg;
    if (state == IDLE) begin
      quarterN = '0;
      bitN = '0;
      if (iCall) begin
        stateN = START;
        shiftN = {DEV_ID, iData};
      end
    end else if (state == WAIT) begin
      stateN = (waitCnt == WAIT_LAST) ? DONE : WAIT;
    end else if (state == DONE) begin
      stateN = IDLE;
    end else if (tick) begin
      quarterN = quarter + 2'd1;
      if (quarter == 2'd3) begin
        if (state == START) stateN = BIT;
        else if (state == BIT) begin
          // Ack slots carry no payload, so the shift register only advances after data bits.
          shiftN = ackBit ? shiftReg : {shiftReg[22:0], 1'b0};
          bitN = lastBit ? '0 : bitCnt + 1'b1;
          stateN = lastBit ? STOP : BIT;
        end else if (state == STOP) stateN = GAP;
        else stateN = softReset ? WAIT : DONE;
      end
    end
  end
  assign busN = busDrive(stateN, quarterN, isAckBit(bitN), shiftN[23]);
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      quarter <= '0;
      bitCnt <= '0;
      shiftReg <= '0;
      waitCnt <= '0;
      softReset <= 1'b0;
      oDone <= 1'b0;
      oBusy <= 1'b0;
      oNack <= 1'b0;
      SIO_C <= 1'b1;
      SIO_D_OUT <= 1'b1;
      SIO_D_OE <= 1'b1;
    end else begin
      state <= stateN;
      quarter <= quarterN;
      bitCnt <= bitN;
      shiftReg <= shiftN;
      waitCnt <= (state == WAIT) ? waitCnt + 1'b1 : '0;
      if (state == IDLE && iCall) softReset <= (iData[15:8] == COM7_ADDR) && iData[7];
      oDone <= (stateN == DONE);
      oBusy <= (stateN != IDLE);
      if (state == IDLE && iCall) oNack <= 1'b0;
      else if (state == BIT && ackBit && quarter == 2'd2 && tick && SIO_D_IN) oNack <= 1'b1;
      SIO_C <= busN.c;
      SIO_D_OUT <= busN.d;
      SIO_D_OE <= busN.oe;
    end
  end
endmodule

// File: doc/sccb_write_funcmod.md
Name: sccb_write_funcmod

Overview:
SCCB (I2C-style) write engine that serves the camera register-sequencer's call/done handshake. It accepts one 16-bit word {register address, register value} per call and drives one complete 3-phase SCCB write: device ID 0x42, sub-address, data. It sits between the camera control sequencer and the OV7670 SIO_C/SIO_D pins, and returns a one-cycle done pulse after each write.

Parameters:
CLK_DIV, 250, system clocks per quarter SCL bit period (100 MHz / (4*250) = 100 kHz SCL); legal range >= 2
DEV_ID, 8'h42, SCCB write ID byte (7-bit address plus W=0)
RST_WAIT, 100_000, extra idle clocks before oDone after a soft-reset write (COM7 0x12 with data bit7 = 1)

Ports:
CLOCK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
iCall  in  1  write request, level; caller holds it high until oDone
iData  in  16  [15:8] register address, [7:0] register value; latched on accept
oDone  out  1  one-cycle pulse when the transaction completes
oBusy  out  1  high from accept until the oDone cycle, inclusive
oNack  out  1  high if any ack slot sampled SIO_D high in the last transaction; cleared on accept
SIO_C  out  1  SCCB clock
SIO_D_OUT  out  1  SCCB data output value
SIO_D_OE  out  1  1 = drive SIO_D_OUT onto the pin, 0 = release
SIO_D_IN  in  1  SCCB data pin readback

Behaviour:
- Reset (asynchronous, any state): state=IDLE, SIO_C=1, SIO_D_OUT=1, SIO_D_OE=1, oDone=0, oBusy=0, oNack=0, tick counter=0, bit counter=0.
- Tick: a quarter-period strobe generated every CLK_DIV clocks. The tick counter restarts at accept, so phase q0 of START begins on the cycle after accept.
- IDLE:
  - When iCall=1, latch iData into a 24-bit shift register as {DEV_ID, iData[15:8], iData[7:0]}.
  - Set oBusy=1, clear oNack, go to START.
  - iCall=0 holds IDLE, with the bus idle (C=1, D=1 driven).
- START, 4 quarters: q0 C=1 D=1; q1 C=1 D=0; q2 C=0 D=0; q3 C=0 D=0.
- BIT, 27 bits: 3 bytes, each 8 data bits MSB first plus one ack slot. Each bit uses 4 quarters:
  - q0: C=0, D=bit.
  - q1 and q2: C=1.
  - q3: C=0.
  - D changes only in q0 while C=0.
- Ack slot (bits 9, 18, 27): SIO_D_OE=0 for all 4 quarters. SIO_D_IN is sampled on the last clock of q2; a high sample sets oNack (sticky). The sequence continues regardless of the ack value (SCCB don't-care).
- STOP, 4 quarters: q0 C=0 D=0 OE=1; q1 C=1 D=0; q2 C=1 D=1; q3 C=1 D=1.
- GAP, 4 quarters: bus idle (bus free time).
- WAIT: entered only when the latched address is 8'h12 and latched data bit7=1. Holds RST_WAIT clocks with the bus idle; otherwise skipped.
- DONE: 1 cycle with oDone=1, then IDLE.
- Latency from accept to oDone: exactly 120*CLK_DIV + 1 clocks without WAIT; add RST_WAIT with WAIT.
- Back-to-back calls:
  - iCall seen high in the cycle after DONE starts a new transaction immediately.
  - The sequencer drops iCall on seeing oDone, so no double accept occurs with that caller.
  - Any caller holding iCall high past DONE gets a second write; this is documented, not guarded.
- iCall falling or iData changing mid-transaction is ignored; the transaction completes and oDone still pulses.
- Tick and bit counters are sized by $clog2 and saturate-free; the bit counter wraps 0..26 only inside BIT.

Decomposition:
- Shared package: state encoding (IDLE, START, BIT, STOP, GAP, WAIT, DONE), SCCB_ID_WRITE = 8'h42, COM7_ADDR = 8'h12.
- One sub-module, sccb_tick_gen: quarter-period strobe with a synchronous restart input.

Test Plan:
1. CLK_DIV=4, iCall with iData=16'h1180, SIO_D_IN tied 0 -> SIO_D bit stream 0x42,0x11,0x80 MSB first; three released ack slots; oDone pulses exactly 481 clocks after accept; oNack=0.
2. Same transaction with SIO_D_IN=1 during the second ack slot only -> oNack=1 after the transaction; next accept clears it to 0.
3. RST_WAIT=50, iData=16'h1280 -> oDone at 481+50 clocks. Control case: iData=16'h1200 -> 481 clocks.
4. Drive the real sequencer model through 3 words -> exactly 3 oDone pulses, 3 complete frames, no duplicate accepts. Checker: SIO_D never changes while SIO_C=1 except at START q1 and STOP q2.
5. Deassert RESET at BIT q1 of byte 2 -> outputs immediately return to reset values. After reset release with iCall=1, a fresh full transaction follows.
6. Toggle iCall low and change iData mid-BIT -> original frame completes unchanged; oDone pulses once.
